// File: rtl/async_fifo_pkg.sv
// ============================================================================
// Module      : async_fifo_pkg
// Description : Shared helpers for the dual-clock FIFO pointer logic.
//               Binary/Gray conversion functions and depth constants used
//               by the write-side full generator, the read-side empty
//               generator and the pointer synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package async_fifo_pkg;

   // Widest pointer the conversion helpers handle. Callers zero-extend
   // their pointer into this width and cast the result back down. Leading
   // zeros do not disturb either conversion.
   localparam int PTR_MAX_W = 32;

   // Default RAM address width and the depth it implies.
   localparam int DEFAULT_AWIDTH = 3;
   localparam int DEPTH          = 2 ** DEFAULT_AWIDTH;

   // Depth for an arbitrary address width.
   function automatic int depth_of(input int awidth);
      return 2 ** awidth;
   endfunction

   function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at and above it.
   function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
      logic [PTR_MAX_W-1:0] bin;
      bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
      for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wptr_full.sv
// ============================================================================
// Module      : fifo_wptr_full
// Description : Write-side pointer and full-flag generator of the dual-clock
//               FIFO. Holds the binary and Gray write pointers, drives the
//               RAM write port and derives full / almost-full / fill level /
//               overflow from the read pointer after it has been
//               synchronized into this clock domain.
// Revision    : 1.0 - initial release
//
// Ports
//   clk_i             in   1         write-domain clock, rising edge
//   aclr_i            in   1         asynchronous active-high reset
//   wrreq_i           in   1         write request for the current cycle
//   rptr_gray_sync_i  in   AWIDTH+1  synchronized Gray read pointer
//   wen_o             out  1         RAM write enable (wrreq_i & ~full_o)
//   waddr_o           out  AWIDTH    RAM write address
//   wptr_gray_o       out  AWIDTH+1  registered Gray write pointer
//   full_o            out  1         registered full flag
//   almost_full_o     out  1         registered, usedw_o >= AF_LEVEL
//   usedw_o           out  AWIDTH+1  registered fill level (pessimistic)
//   overflow_o        out  1         one-cycle pulse: write dropped while full
// ============================================================================
`default_nettype none

module fifo_wptr_full
   import async_fifo_pkg::*;
#(
   parameter int AWIDTH   = 3,
   parameter int AF_LEVEL = 2 ** AWIDTH - 2
) (
   input  logic              clk_i,
   input  logic              aclr_i,
   input  logic              wrreq_i,
   input  logic [AWIDTH:0]   rptr_gray_sync_i,
   output logic              wen_o,
   output logic [AWIDTH-1:0] waddr_o,
   output logic [AWIDTH:0]   wptr_gray_o,
   output logic              full_o,
   output logic              almost_full_o,
   output logic [AWIDTH:0]   usedw_o,
   output logic              overflow_o
);

   localparam int PTR_W = AWIDTH + 1;

   // Full means the write pointer sits exactly one lap ahead of the read
   // pointer. In Gray code that is the read pointer with its two top bits
   // inverted. Expressed as a mask so AWIDTH = 1 needs no special case.
   localparam logic [PTR_W-1:0] c_full_mask = PTR_W'(3) << (AWIDTH - 1);
   localparam logic [PTR_W-1:0] c_af_level  = PTR_W'(AF_LEVEL);

   logic [PTR_W-1:0] r_wbin;
   logic [PTR_W-1:0] r_wgray;
   logic             r_full;
   logic             r_almost_full;
   logic [PTR_W-1:0] r_usedw;
   logic             r_overflow;

   logic             w_wen;
   logic [PTR_W-1:0] w_wbin_next;
   logic [PTR_W-1:0] w_wgray_next;
   logic [PTR_W-1:0] w_rbin;
   logic [PTR_W-1:0] w_usedw_next;
   logic             w_full_next;
   logic             w_almost_full_next;

   // A write is taken only while the registered full flag is low. Writes
   // presented while full are dropped and reported through overflow_o.
   assign w_wen        = wrreq_i & ~r_full;
   assign w_wbin_next  = r_wbin + PTR_W'(w_wen);
   assign w_wgray_next = PTR_W'(bin2gray(PTR_MAX_W'(w_wbin_next)));
   assign w_rbin       = PTR_W'(gray2bin(PTR_MAX_W'(rptr_gray_sync_i)));

   // Both the next write pointer and the current read pointer feed the
   // flags, so a write and a read step in the same cycle cancel out.
   // The read pointer lags the real one, so this level can only overstate.
   assign w_usedw_next       = w_wbin_next - w_rbin;
   assign w_full_next        = (w_wgray_next == (rptr_gray_sync_i ^ c_full_mask));
   assign w_almost_full_next = (w_usedw_next >= c_af_level);

   always_ff @(posedge clk_i or posedge aclr_i) begin
      if (aclr_i) begin
         r_wbin        <= '0;
         r_wgray       <= '0;
         r_full        <= 1'b0;
         r_almost_full <= 1'b0;
         r_usedw       <= '0;
         r_overflow    <= 1'b0;
      end else begin
         r_wbin        <= w_wbin_next;
         r_wgray       <= w_wgray_next;
         r_full        <= w_full_next;
         r_almost_full <= w_almost_full_next;
         r_usedw       <= w_usedw_next;
         r_overflow    <= wrreq_i & r_full;
      end
   end

   assign wen_o         = w_wen;
   assign waddr_o       = r_wbin[AWIDTH-1:0];
   assign wptr_gray_o   = r_wgray;
   assign full_o        = r_full;
   assign almost_full_o = r_almost_full;
   assign usedw_o       = r_usedw;
   assign overflow_o    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_fifo_wptr_full.sv
// ============================================================================
// Module      : tb_fifo_wptr_full
// Description : Self-checking bench for fifo_wptr_full (AWIDTH=3,
//               AF_LEVEL=6). A counting model tracks total writes accepted
//               and total reads, and the outputs are checked against it
//               every falling edge. Directed scenarios add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wptr_full;

   localparam int AW = 3;
   localparam int AF = 6;

   logic          clk;
   logic          aclr;
   logic          wrreq;
   logic [AW:0]   rptr;
   logic          wen;
   logic [AW-1:0] waddr;
   logic [AW:0]   wgray;
   logic          full;
   logic          afull;
   logic [AW:0]   usedw;
   logic          ovf;

   int n_cmp = 0;
   int n_err = 0;

   // Model state: total writes accepted and reads seen, plus the flags.
   int   m_w;
   int   rcnt;
   int   m_used;
   logic m_full;
   logic m_af;
   logic m_of;

   logic [AW:0] prev_g;
   bit          prev_ok;

   fifo_wptr_full #(.AWIDTH(AW), .AF_LEVEL(AF)) dut (
      .clk_i            (clk),
      .aclr_i           (aclr),
      .wrreq_i          (wrreq),
      .rptr_gray_sync_i (rptr),
      .wen_o            (wen),
      .waddr_o          (waddr),
      .wptr_gray_o      (wgray),
      .full_o           (full),
      .almost_full_o    (afull),
      .usedw_o          (usedw),
      .overflow_o       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [AW:0] gray_of(input int n);
      logic [AW:0] b;
      b = (AW+1)'(n % 16);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Occupancy model: the FIFO holds (writes accepted - reads) entries.
   always @(posedge clk or posedge aclr) begin
      if (aclr) begin
         m_w = 0; m_used = 0; m_full = 0; m_af = 0; m_of = 0;
      end else begin
         bit acc;
         acc    = wrreq && !m_full;
         m_of   = wrreq && m_full;
         m_w    = m_w + (acc ? 1 : 0);
         m_used = m_w - rcnt;
         m_full = (m_used == 8);
         m_af   = (m_used >= AF);
      end
   end

   always @(negedge clk) begin
      chk("wen",   int'(wen),   int'(wrreq & ~m_full));
      chk("waddr", int'(waddr), m_w % 8);
      chk("wgray", int'(wgray), int'(gray_of(m_w)));
      chk("full",  int'(full),  int'(m_full));
      chk("afull", int'(afull), int'(m_af));
      chk("usedw", int'(usedw), m_used);
      chk("ovf",   int'(ovf),   int'(m_of));
      if (aclr) begin
         prev_ok = 0;
      end else begin
         if (prev_ok) chk("gray_onebit", ($countones(wgray ^ prev_g) <= 1) ? 1 : 0, 1);
         prev_g  = wgray;
         prev_ok = 1;
      end
   end

   // Apply inputs for one cycle, then return 1 ns after the edge.
   task automatic cyc(input bit wr, input bit rd);
      wrreq = wr;
      if (rd) rcnt++;
      rptr = gray_of(rcnt);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      #2 aclr = 1'b1;
      wrreq = 1'b0; rcnt = 0; rptr = '0;
      #13 aclr = 1'b0;
      @(posedge clk); #1;
   endtask

   logic [AW:0] gtab [0:8];

   initial begin
      gtab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
      aclr = 1'b1; wrreq = 1'b0; rcnt = 0; rptr = '0; prev_ok = 0;
      #1;
      chk("reset_gray",  int'(wgray), 0);
      chk("reset_usedw", int'(usedw), 0);
      chk("reset_full",  int'(full),  0);
      do_reset();

      // 1: eight writes into an empty FIFO
      for (int i = 0; i < 8; i++) begin
         wrreq = 1'b1; #1;
         chk("s1_waddr", int'(waddr), i);
         chk("s1_wen",   int'(wen),   1);
         cyc(1, 0);
         chk("s1_gray", int'(wgray), int'(gtab[i+1]));
         if (i == 4) chk("s1_af_after5", int'(afull), 0);
         if (i == 5) chk("s1_af_after6", int'(afull), 1);
         if (i == 6) chk("s1_full_after7", int'(full), 0);
      end
      chk("s1_full",  int'(full),  1);
      chk("s1_usedw", int'(usedw), 8);

      // 2: writes while full are dropped and flagged
      for (int i = 0; i < 3; i++) begin
         wrreq = 1'b1; #1;
         chk("s2_wen", int'(wen), 0);
         cyc(1, 0);
         chk("s2_ovf",  int'(ovf),   1);
         chk("s2_gray", int'(wgray), 12);
      end
      cyc(0, 0);
      chk("s2_ovf_end", int'(ovf), 0);

      // 3: a read step clears full, then one more write refills
      cyc(0, 1);
      chk("s3_full",  int'(full),  0);
      chk("s3_usedw", int'(usedw), 7);
      wrreq = 1'b1; #1;
      chk("s3_wen", int'(wen), 1);
      cyc(1, 0);
      chk("s3_refull", int'(full),  1);
      chk("s3_usedw8", int'(usedw), 8);
      cyc(0, 0);

      // 4: steady level 2 across a pointer wrap
      do_reset();
      cyc(1, 0);
      cyc(1, 0);
      for (int i = 0; i < 20; i++) begin
         cyc(1, 1);
         chk("s4_usedw", int'(usedw), 2);
         chk("s4_full",  int'(full),  0);
      end
      chk("s4_gray_wrapped", int'(wgray), 5);   // wbin = 22 mod 16 = 6
      cyc(0, 0);

      // 5: simultaneous write and read at level 7
      do_reset();
      for (int i = 0; i < 7; i++) cyc(1, 0);
      chk("s5_usedw7", int'(usedw), 7);
      cyc(1, 1);
      chk("s5_usedw", int'(usedw), 7);
      chk("s5_full",  int'(full),  0);
      cyc(0, 0);

      // 6: asynchronous reset in the middle of a burst
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1, 0);
      chk("s6_usedw5", int'(usedw), 5);
      #2 aclr = 1'b1; wrreq = 1'b0; rcnt = 0; rptr = '0;
      #1;
      chk("s6_gray",  int'(wgray), 0);
      chk("s6_waddr", int'(waddr), 0);
      chk("s6_usedw", int'(usedw), 0);
      chk("s6_af",    int'(afull), 0);
      chk("s6_full",  int'(full),  0);
      chk("s6_ovf",   int'(ovf),   0);
      chk("s6_wen",   int'(wen),   0);
      #10 aclr = 1'b0;
      @(posedge clk); #1;
      wrreq = 1'b1; #1;
      chk("s6_first_waddr", int'(waddr), 0);
      chk("s6_first_wen",   int'(wen),   1);
      cyc(1, 0);
      chk("s6_after_write", int'(usedw), 1);
      cyc(0, 0);
      cyc(0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
